// File: rtl/rmt_operand_xbar_v2.sv
// Operand crossbar for one RMT action stage with a valid/ready output skid.
// Ports: clk/rst_n; phv_in, action_in + valids, in_ready; alu_in_* operands,
// phv_remain_data, action_out, idx_err, idx_err_sticky, beat_count.
module rmt_operand_xbar_v2 #(
    parameter int STAGE_ID = 0,
    parameter int NUM_CONT = 64,
    parameter int CONT_W   = 32,
    parameter int IDX_W    = 6,
    parameter int META_W   = 256,
    parameter int ACT_W    = 64,
    parameter int PHV_LEN  = NUM_CONT*CONT_W+META_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PHV_LEN-1:0]           phv_in,
    input  logic                         phv_in_valid,
    input  logic [(NUM_CONT+1)*ACT_W-1:0] action_in,
    input  logic                         action_in_valid,
    output logic                         in_ready,
    output logic                         alu_in_valid,
    input  logic                         alu_in_ready,
    output logic [NUM_CONT*CONT_W-1:0]   alu_in_a,
    output logic [NUM_CONT*CONT_W-1:0]   alu_in_b,
    output logic [NUM_CONT*CONT_W-1:0]   alu_in_c,
    output logic [META_W-1:0]            phv_remain_data,
    output logic [(NUM_CONT+1)*ACT_W-1:0] action_out,
    output logic [NUM_CONT-1:0]          idx_err,
    output logic                         idx_err_sticky,
    output logic [31:0]                  beat_count
);

    localparam int OPS_W  = NUM_CONT*CONT_W;
    localparam int ACTS_W = (NUM_CONT+1)*ACT_W;
    localparam int BEAT_W = 3*OPS_W + META_W + ACTS_W + NUM_CONT;
    localparam int NPAD   = 1 << IDX_W;
    localparam logic [31:0] NC32 = 32'(NUM_CONT);

    // Reject illegal parameter sets at elaboration time.
    if (IDX_W < $clog2(NUM_CONT) || ACT_W < 8+2*IDX_W+CONT_W ||
        NUM_CONT < 2 || NUM_CONT > 64 || STAGE_ID < 0) begin : g_bad_params
        $error("rmt_operand_xbar_v2: illegal parameters");
    end

    // Container table padded to the full index range; entries past
    // NUM_CONT read as zero so an out-of-range operand becomes 0.
    logic [CONT_W-1:0] cont_pad [NPAD];

    for (genvar j = 0; j < NPAD; j++) begin : g_pad
        if (j < NUM_CONT) begin : g_live
            assign cont_pad[j] = phv_in[META_W + j*CONT_W +: CONT_W];
        end else begin : g_zero
            assign cont_pad[j] = '0;
        end
    end

    logic [OPS_W-1:0]    a_n;
    logic [OPS_W-1:0]    b_n;
    logic [OPS_W-1:0]    c_n;
    logic [NUM_CONT-1:0] err_n;

    for (genvar i = 0; i < NUM_CONT; i++) begin : g_dec
        localparam int BASE = (i+1)*ACT_W;
        logic [7:0]        op;
        logic [IDX_W-1:0]  sa;
        logic [IDX_W-1:0]  sb;
        logic [CONT_W-1:0] imm;
        logic              sa_oor;
        logic              sb_oor;
        logic [CONT_W-1:0] a_i;
        logic [CONT_W-1:0] b_i;
        logic              e_i;

        assign op     = action_in[BASE + ACT_W-1 -: 8];
        assign sa     = action_in[BASE + ACT_W-9 -: IDX_W];
        assign sb     = action_in[BASE + ACT_W-9-IDX_W -: IDX_W];
        assign imm    = action_in[BASE +: CONT_W];
        assign sa_oor = 32'(sa) >= NC32;
        assign sb_oor = 32'(sb) >= NC32;

        always_comb begin
            a_i = cont_pad[i];
            b_i = '0;
            e_i = 1'b0;
            case (op)
                8'h01, 8'h02, 8'h07, 8'h08, 8'h0B: begin
                    a_i = cont_pad[sa];
                    b_i = cont_pad[sb];
                    e_i = sa_oor | sb_oor;
                end
                8'h09, 8'h0A: begin
                    a_i = cont_pad[sa];
                    b_i = imm;
                    e_i = sa_oor;
                end
                8'h0E: begin
                    a_i = '0;
                    b_i = imm;
                end
                default: ;
            endcase
        end

        assign a_n[i*CONT_W +: CONT_W] = a_i;
        assign b_n[i*CONT_W +: CONT_W] = b_i;
        assign c_n[i*CONT_W +: CONT_W] = cont_pad[i];
        assign err_n[i]                = e_i;
    end

    logic [BEAT_W-1:0] beat_new;
    assign beat_new = {a_n, b_n, c_n, phv_in[META_W-1:0], action_in, err_n};

    logic [BEAT_W-1:0] out_q, out_d;
    logic [BEAT_W-1:0] skid_q, skid_d;
    logic              out_vld_q, out_vld_d;
    logic              skid_full_q, skid_full_d;
    logic              in_ready_q, in_ready_d;
    logic              sticky_q, sticky_d;
    logic [31:0]       cnt_q, cnt_d;

    logic accept;
    logic xfer;

    assign accept = phv_in_valid & action_in_valid & in_ready_q;
    assign xfer   = out_vld_q & alu_in_ready;

    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_vld_d   = out_vld_q;
        skid_full_d = skid_full_q;
        if (xfer) begin
            // in_ready is low whenever the skid is full, so a skid
            // refill and a new accept can never coincide.
            if (skid_full_q) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d = beat_new;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_vld_q) begin
                out_d     = beat_new;
                out_vld_d = 1'b1;
            end else begin
                skid_d      = beat_new;
                skid_full_d = 1'b1;
            end
        end
        in_ready_d = ~skid_full_d;
        cnt_d      = cnt_q + {31'd0, xfer};
        sticky_d   = sticky_q | (xfer & (|out_q[NUM_CONT-1:0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_vld_q   <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_vld_q   <= out_vld_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign {alu_in_a, alu_in_b, alu_in_c,
            phv_remain_data, action_out, idx_err} = out_q;
    assign alu_in_valid   = out_vld_q;
    assign in_ready       = in_ready_q;
    assign idx_err_sticky = sticky_q;
    assign beat_count     = cnt_q;

endmodule

// File: tb/tb_rmt_operand_xbar_v2.sv
// Directed bench for rmt_operand_xbar_v2 with NUM_CONT=48.
// Hand-computed vectors: identity, mixed ops, idx errors, skid, reset.
module tb_rmt_operand_xbar_v2;

    localparam int NC = 48;
    localparam int CW = 32;
    localparam int IW = 6;
    localparam int MW = 256;
    localparam int AW = 64;
    localparam int PL = NC*CW + MW;
    localparam int AL = (NC+1)*AW;
    localparam int OW = NC*CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PL-1:0] phv;
    logic          phv_v;
    logic [AL-1:0] act;
    logic          act_v;
    logic          in_ready;
    logic          out_v;
    logic          out_rdy;
    logic [OW-1:0] a_o, b_o, c_o;
    logic [MW-1:0] meta_o;
    logic [AL-1:0] act_o;
    logic [NC-1:0] err_o;
    logic          sticky_o;
    logic [31:0]   cnt_o;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rmt_operand_xbar_v2 #(
        .STAGE_ID(3), .NUM_CONT(NC), .CONT_W(CW), .IDX_W(IW),
        .META_W(MW), .ACT_W(AW), .PHV_LEN(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv), .phv_in_valid(phv_v),
        .action_in(act), .action_in_valid(act_v),
        .in_ready(in_ready),
        .alu_in_valid(out_v), .alu_in_ready(out_rdy),
        .alu_in_a(a_o), .alu_in_b(b_o), .alu_in_c(c_o),
        .phv_remain_data(meta_o), .action_out(act_o),
        .idx_err(err_o), .idx_err_sticky(sticky_o),
        .beat_count(cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] aw(input logic [7:0] op,
        input logic [5:0] sa, input logic [5:0] sb, input logic [31:0] imm);
        return {op, sa, sb, 12'h000, imm};
    endfunction

    function automatic logic [31:0] cv(input int i);
        return 32'(i) * 32'h01010101;
    endfunction

    task automatic set_cont(input int i, input logic [31:0] v);
        phv[MW + i*CW +: CW] = v;
    endtask

    task automatic set_slot(input int k, input logic [AW-1:0] w);
        act[k*AW +: AW] = w;
    endtask

    task automatic set_meta(input logic [63:0] m);
        phv[MW-1:0] = '0;
        phv[63:0]   = m;
    endtask

    function automatic logic [31:0] ga(input int i);
        return a_o[i*CW +: CW];
    endfunction
    function automatic logic [31:0] gb(input int i);
        return b_o[i*CW +: CW];
    endfunction
    function automatic logic [31:0] gc(input int i);
        return c_o[i*CW +: CW];
    endfunction

    initial begin
        rst_n   = 1'b0;
        phv     = '0;
        act     = '0;
        phv_v   = 1'b0;
        act_v   = 1'b0;
        out_rdy = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(out_v), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(cnt_o), 64'd0);
        check("rst_sticky", 64'(sticky_o), 64'd0);
        check("rst_a0", 64'(ga(0)), 64'd0);
        rst_n = 1'b1;
        tick();

        // identity pass
        for (int i = 0; i < NC; i++) set_cont(i, cv(i));
        set_meta(64'h1);
        out_rdy = 1'b1;
        phv_v   = 1'b1;
        act_v   = 1'b1;
        tick();
        phv_v = 1'b0;
        act_v = 1'b0;
        check("id_valid", 64'(out_v), 64'd1);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("id_a%0d", i), 64'(ga(i)), 64'(cv(i)));
            check($sformatf("id_b%0d", i), 64'(gb(i)), 64'd0);
            check($sformatf("id_c%0d", i), 64'(gc(i)), 64'(cv(i)));
        end
        check("id_err", 64'(err_o), 64'd0);
        check("id_meta", meta_o[63:0], 64'h1);
        tick();
        check("id_count", 64'(cnt_o), 64'd1);
        check("id_drain", 64'(out_v), 64'd0);

        // mixed opcodes
        set_slot(6, aw(8'h01, 6'd2, 6'd3, 32'h0));
        set_slot(7, aw(8'h09, 6'd2, 6'd0, 32'hDEADBEEF));
        set_slot(8, aw(8'h0E, 6'd0, 6'd0, 32'hCAFEF00D));
        set_slot(9, aw(8'h0A, 6'd4, 6'd0, 32'h55));
        set_slot(10, aw(8'h09, 6'd1, 6'd63, 32'h77));
        set_slot(11, aw(8'h0E, 6'd60, 6'd61, 32'h99));
        set_slot(12, aw(8'h03, 6'd63, 6'd63, 32'h11));
        set_meta(64'h2);
        phv_v = 1'b1;
        act_v = 1'b1;
        tick();
        phv_v = 1'b0;
        act_v = 1'b0;
        check("mx_a5", 64'(ga(5)), 64'(cv(2)));
        check("mx_b5", 64'(gb(5)), 64'(cv(3)));
        check("mx_c5", 64'(gc(5)), 64'(cv(5)));
        check("mx_a6", 64'(ga(6)), 64'(cv(2)));
        check("mx_b6", 64'(gb(6)), 64'hDEADBEEF);
        check("mx_a7", 64'(ga(7)), 64'd0);
        check("mx_b7", 64'(gb(7)), 64'hCAFEF00D);
        check("mx_a8", 64'(ga(8)), 64'(cv(4)));
        check("mx_b8", 64'(gb(8)), 64'h55);
        check("mx_a9", 64'(ga(9)), 64'(cv(1)));
        check("mx_a11", 64'(ga(11)), 64'(cv(11)));
        check("mx_b11", 64'(gb(11)), 64'd0);
        check("mx_err", 64'(err_o), 64'd0);
        check("mx_act", 64'(act_o == act), 64'd1);
        tick();
        check("mx_count", 64'(cnt_o), 64'd2);

        // valid mismatch
        act   = '0;
        phv_v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mm_valid%0d", k), 64'(out_v), 64'd0);
        end
        phv_v = 1'b0;
        check("mm_count", 64'(cnt_o), 64'd2);
        check("mm_ready", 64'(in_ready), 64'd1);

        // out-of-range index
        set_slot(1, aw(8'h01, 6'd50, 6'd1, 32'h0));
        set_meta(64'h3);
        out_rdy = 1'b0;
        phv_v   = 1'b1;
        act_v   = 1'b1;
        tick();
        phv_v = 1'b0;
        act_v = 1'b0;
        check("ie_valid", 64'(out_v), 64'd1);
        check("ie_a0", 64'(ga(0)), 64'd0);
        check("ie_b0", 64'(gb(0)), 64'(cv(1)));
        check("ie_err", 64'(err_o), 64'h1);
        check("ie_sticky0", 64'(sticky_o), 64'd0);
        out_rdy = 1'b1;
        tick();
        check("ie_count", 64'(cnt_o), 64'd3);
        check("ie_sticky1", 64'(sticky_o), 64'd1);
        tick();
        tick();
        check("ie_sticky2", 64'(sticky_o), 64'd1);

        // backpressure through the skid
        act     = '0;
        out_rdy = 1'b0;
        phv_v   = 1'b1;
        act_v   = 1'b1;
        set_meta(64'd11);
        set_cont(0, 32'hB1);
        tick();
        check("bp_v1", 64'(out_v), 64'd1);
        check("bp_rdy1", 64'(in_ready), 64'd1);
        check("bp_m1", meta_o[63:0], 64'd11);
        set_meta(64'd12);
        set_cont(0, 32'hB2);
        tick();
        check("bp_rdy2", 64'(in_ready), 64'd0);
        check("bp_m2", meta_o[63:0], 64'd11);
        set_meta(64'd13);
        set_cont(0, 32'hB3);
        tick();
        check("bp_hold_m", meta_o[63:0], 64'd11);
        check("bp_hold_a", 64'(ga(0)), 64'hB1);
        check("bp_rdy3", 64'(in_ready), 64'd0);
        out_rdy = 1'b1;
        tick();
        check("bp_o2_m", meta_o[63:0], 64'd12);
        check("bp_o2_a", 64'(ga(0)), 64'hB2);
        check("bp_o2_v", 64'(out_v), 64'd1);
        check("bp_o2_rdy", 64'(in_ready), 64'd1);
        check("bp_o2_cnt", 64'(cnt_o), 64'd4);
        tick();
        phv_v = 1'b0;
        act_v = 1'b0;
        check("bp_o3_m", meta_o[63:0], 64'd13);
        check("bp_o3_a", 64'(ga(0)), 64'hB3);
        check("bp_o3_v", 64'(out_v), 64'd1);
        check("bp_o3_cnt", 64'(cnt_o), 64'd5);
        tick();
        check("bp_end_v", 64'(out_v), 64'd0);
        check("bp_end_cnt", 64'(cnt_o), 64'd6);

        // reset while stalled with skid full
        out_rdy = 1'b0;
        phv_v   = 1'b1;
        act_v   = 1'b1;
        tick();
        tick();
        phv_v = 1'b0;
        act_v = 1'b0;
        check("rs_full", 64'(in_ready), 64'd0);
        check("rs_v", 64'(out_v), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_valid", 64'(out_v), 64'd0);
        check("rs_ready", 64'(in_ready), 64'd1);
        check("rs_count", 64'(cnt_o), 64'd0);
        check("rs_sticky", 64'(sticky_o), 64'd0);
        check("rs_a0", 64'(ga(0)), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rmt_operand_xbar_v2.md
Name: rmt_operand_xbar_v2

Overview:
- Parametrised successor of the stage-level operand crossbar in the RMT action engine.
- Builds per-container ALU operands A/B/C from the PHV containers and per-container action words.
- Sits between the PHV/action-table outputs and the ALU array of one stage.
- Adds generic container count and width, a real valid/ready pipeline with a 2-entry skid buffer, action words aligned to the operands, and out-of-range index detection.

Parameters:
- STAGE_ID, 0, stage number; informational only.
- NUM_CONT, 64, number of PHV containers; range 2..64.
- CONT_W, 32, container width in bits.
- IDX_W, 6, operand-index field width; must be ≥ clog2(NUM_CONT).
- META_W, 256, width of the metadata tail of the PHV; passed through untouched.
- ACT_W, 64, width of one action word; must be ≥ 8+2*IDX_W+CONT_W.
- PHV_LEN, NUM_CONT*CONT_W+META_W, total PHV width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- phv_in  in  PHV_LEN  container i at [PHV_LEN-1-CONT_W*(NUM_CONT-1-i) -: CONT_W]; metadata at [META_W-1:0].
- phv_in_valid  in  1  PHV valid.
- action_in  in  (NUM_CONT+1)*ACT_W  slot k at [k*ACT_W +: ACT_W]; slot 0 reserved; slot i+1 drives container i.
- action_in_valid  in  1  action valid.
- in_ready  out  1  block can accept a beat.
- alu_in_valid  out  1  output beat valid.
- alu_in_ready  in  1  ALU array accepts the beat.
- alu_in_a, alu_in_b, alu_in_c  out  NUM_CONT*CONT_W  operands; container i at [(i+1)*CONT_W-1 -: CONT_W].
- phv_remain_data  out  META_W  metadata passthrough.
- action_out  out  (NUM_CONT+1)*ACT_W  action words aligned with the operands.
- idx_err  out  NUM_CONT  per-container out-of-range flags for the current output beat.
- idx_err_sticky  out  1  set when any beat with an idx_err bit transfers; cleared only by reset.
- beat_count  out  32  number of output transfers; wraps modulo 2^32.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. All outputs go to 0 except in_ready=1. Skid buffer empty.
- Input handshake: accept = phv_in_valid & action_in_valid & in_ready. If only one of the two valids is high, nothing is accepted and no state changes.
- Action word fields: opcode=[ACT_W-1 -: 8]; srcA=[ACT_W-9 -: IDX_W]; srcB=[ACT_W-9-IDX_W -: IDX_W]; imm=[CONT_W-1:0].
- Per-container decode (i = 0..NUM_CONT-1):
  - C = cont[i] always.
  - Opcode 0x01, 0x02, 0x07, 0x08, 0x0B: A=cont[srcA], B=cont[srcB].
  - Opcode 0x09, 0x0A: A=cont[srcA], B=imm.
  - Opcode 0x0E: A=0, B=imm.
  - Any other opcode: A=cont[i], B=0.
- Out-of-range index: an index ≥ NUM_CONT that the opcode actually uses makes the affected operand 0 and sets idx_err[i]. Unused indices are ignored.
- Latency: 1 cycle from accept to alu_in_valid when the output stage is empty or draining. Operands, phv_remain_data, action_out and idx_err are registered together as one beat.
- Output transfer: alu_in_valid & alu_in_ready.
  - While alu_in_valid=1 and alu_in_ready=0, all output data is held stable.
  - No bubble on continuous flow.
- Skid buffer:
  - If an accept occurs while the output register holds a beat and is not transferring, the new beat goes to the skid register.
  - in_ready is registered and equals !skid_full.
  - On transfer with skid full, the skid beat moves to the output register and in_ready returns to 1 next cycle.
  - A simultaneous accept and transfer with skid empty loads the new beat directly into the output register.
- Ordering: beats are strictly in order; never dropped or duplicated.
- beat_count increments on each output transfer; it wraps from 0xFFFFFFFF to 0.
- Reset mid-operation: both the output register and the skid register are discarded immediately.

Test Plan:
- Identity pass: cont[i]=i*0x01010101, all opcodes 0x00, alu_in_ready=1 → next cycle alu_in_a[i]=cont[i], alu_in_b[i]=0, alu_in_c[i]=cont[i], idx_err=0, beat_count=1.
- Mixed ops on container 5:
  - slot 6 opcode 0x01, srcA=2, srcB=3 → a[5]=cont[2], b[5]=cont[3].
  - Opcode 0x09, imm=0xDEADBEEF → a[5]=cont[2], b[5]=0xDEADBEEF.
  - Opcode 0x0E → a[5]=0, b[5]=imm.
- Backpressure: alu_in_ready=0, three back-to-back beats offered → beat 1 held in output, beat 2 in skid, in_ready=0, beat 3 stalled. Then release alu_in_ready → beats 1, 2, 3 emerge in order on consecutive cycles, data unchanged.
- Valid mismatch: phv_in_valid=1, action_in_valid=0 for 4 cycles → alu_in_valid stays 0, beat_count unchanged.
- NUM_CONT=48: container 0 opcode 0x01 with srcA=50 → a[0]=0, idx_err[0]=1. After transfer, idx_err_sticky=1 and stays set.
- Reset mid-stall: skid full, assert rst_n=0 → same cycle alu_in_valid=0, in_ready=1, beat_count=0.
